// File: rtl/dmem_access_arbiter_if.sv
// Requester-side bus of the data-memory arbiter: two request ports plus the shared response.
// The master modport is the requesters' view and the slave modport is the arbiter's view.
interface dmem_access_arbiter_if #(
    parameter int ADDR_W = 7,
    parameter int DATA_W = 32
);
    logic              req0;
    logic              req1;
    logic              we0;
    logic              we1;
    logic [ADDR_W-1:0] addr0;
    logic [ADDR_W-1:0] addr1;
    logic [DATA_W-1:0] wdata0;
    logic [DATA_W-1:0] wdata1;
    logic              gnt0;
    logic              gnt1;
    logic              rvalid0;
    logic              rvalid1;
    logic [DATA_W-1:0] rdata;
    logic              busy;

    modport master (
        output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1,
        input  gnt0, gnt1, rvalid0, rvalid1, rdata, busy
    );

    modport slave (
        input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1,
        output gnt0, gnt1, rvalid0, rvalid1, rdata, busy
    );
endinterface

// File: rtl/dmem_access_arbiter.sv
// Two-port arbiter for a single-port data memory: one transaction in flight, registered strobes.
// Define DMEM_ARB_RR_EN for round-robin tie-breaking; the default build uses fixed priority to port 0.
module dmem_access_arbiter #(
    parameter int ADDR_W   = 7,
    parameter int DATA_W   = 32,
    parameter int READ_LAT = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    dmem_access_arbiter_if.slave bus,
    output logic                CEN,
    output logic                WEN,
    output logic                OEN,
    output logic [ADDR_W-1:0]   A,
    output logic [DATA_W-1:0]   Data2Mem,
    input  logic [DATA_W-1:0]   ReadDataMem
);
    typedef enum logic [1:0] {ST_IDLE, ST_ACCESS, ST_WAIT, ST_RESP} state_t;

    state_t            r_state;
    state_t            w_state_next;
    logic [3:0]        r_cnt;
    logic              r_last_owner;
    logic              r_we;
    logic              r_cen;
    logic              r_wen;
    logic              r_oen;
    logic [ADDR_W-1:0] r_a;
    logic [DATA_W-1:0] r_data2mem;
    logic [DATA_W-1:0] r_rdata;
    logic              r_gnt0;
    logic              r_gnt1;
    logic              r_rvalid0;
    logic              r_rvalid1;
    logic              r_busy;

    logic              w_req_any;
    logic              w_win;
    logic              w_we_sel;
    logic [ADDR_W-1:0] w_addr_sel;
    logic [DATA_W-1:0] w_wdata_sel;

    assign w_req_any = bus.req0 | bus.req1;

`ifdef DMEM_ARB_RR_EN
    // On a tie the port that did not win last time goes first.
    assign w_win = (bus.req0 & bus.req1) ? ~r_last_owner : ~bus.req0;
`else
    assign w_win = ~bus.req0;
`endif

    assign w_we_sel    = w_win ? bus.we1    : bus.we0;
    assign w_addr_sel  = w_win ? bus.addr1  : bus.addr0;
    assign w_wdata_sel = w_win ? bus.wdata1 : bus.wdata0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE:   if (w_req_any) w_state_next = ST_ACCESS;
            ST_ACCESS: w_state_next = r_we ? ST_IDLE : ST_WAIT;
            ST_WAIT:   if (r_cnt == 4'd0) w_state_next = ST_RESP;
            ST_RESP:   w_state_next = ST_IDLE;
            default:   w_state_next = ST_IDLE;
        endcase
    end

    // Outputs are computed one edge early so every pin comes straight from a flop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt        <= 4'd0;
            r_last_owner <= 1'b1;
            r_we         <= 1'b0;
            r_cen        <= 1'b1;
            r_wen        <= 1'b1;
            r_oen        <= 1'b1;
            r_a          <= '0;
            r_data2mem   <= '0;
            r_rdata      <= '0;
            r_gnt0       <= 1'b0;
            r_gnt1       <= 1'b0;
            r_rvalid0    <= 1'b0;
            r_rvalid1    <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            r_cen     <= 1'b1;
            r_wen     <= 1'b1;
            r_oen     <= 1'b1;
            r_gnt0    <= 1'b0;
            r_gnt1    <= 1'b0;
            r_rvalid0 <= 1'b0;
            r_rvalid1 <= 1'b0;
            r_busy    <= (w_state_next != ST_IDLE);
            case (r_state)
                ST_IDLE: begin
                    if (w_req_any) begin
                        r_last_owner <= w_win;
                        r_we         <= w_we_sel;
                        r_a          <= w_addr_sel;
                        r_data2mem   <= w_wdata_sel;
                        r_cen        <= 1'b0;
                        r_wen        <= ~w_we_sel;
                        r_oen        <= w_we_sel;
                        r_gnt0       <= ~w_win;
                        r_gnt1       <= w_win;
                    end
                end
                ST_ACCESS: begin
                    if (!r_we) r_cnt <= 4'(READ_LAT - 1);
                end
                ST_WAIT: begin
                    if (r_cnt != 4'd0) begin
                        r_cnt <= r_cnt - 4'd1;
                    end else begin
                        r_rdata   <= ReadDataMem;
                        r_rvalid0 <= ~r_last_owner;
                        r_rvalid1 <= r_last_owner;
                    end
                end
                default: ;
            endcase
        end
    end

    assign CEN         = r_cen;
    assign WEN         = r_wen;
    assign OEN         = r_oen;
    assign A           = r_a;
    assign Data2Mem    = r_data2mem;
    assign bus.gnt0    = r_gnt0;
    assign bus.gnt1    = r_gnt1;
    assign bus.rvalid0 = r_rvalid0;
    assign bus.rvalid1 = r_rvalid1;
    assign bus.rdata   = r_rdata;
    assign bus.busy    = r_busy;
endmodule
